// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
//
// Purpose:
//   APB initiator that issues single register reads/writes to the I2S
//   transceiver's APB register slave. A host-side sequencer (test driver, DMA,
//   config loader) hands over one command at a time on a valid/ready channel.
//   The block runs the APB SETUP and ACCESS phases, waits for pready with a
//   bounded timeout, and returns exactly one response per accepted command.
//   Commands and responses complete in issue order.
//
// Parameters:
//   ADDR_W   width of cmd_addr / paddr
//   DATA_W   width of write and read data
//   TIMEOUT  maximum ACCESS cycles spent waiting for pready before the
//            transfer is aborted; 0 waits forever
//
// Ports:
//   pclk, preset                 clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write/cmd_addr/cmd_wdata command payload (wdata ignored for reads)
//   psel/penable/pwrite          APB control
//   paddr/pwdata                 APB address and write data
//   prdata/pready/pslverr        APB slave return path
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata                    read data (0 for writes and aborted reads)
//   rsp_err                      slave error or timeout
//   rsp_timeout                  transfer aborted by the timeout
// -----------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout
);

  // The wait counter must be able to hold TIMEOUT; keep at least one bit so
  // the TIMEOUT=0 (wait forever) build still has a legal vector.
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  // Counter value on the last ACCESS cycle that is still allowed to wait.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            state_q,       state_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic              cmd_ready_q,   cmd_ready_d;
  logic              psel_q,        psel_d;
  logic              penable_q,     penable_d;
  logic              pwrite_q,      pwrite_d;
  logic [ADDR_W-1:0] paddr_q,       paddr_d;
  logic [DATA_W-1:0] pwdata_q,      pwdata_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              rsp_err_q,     rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic              timeout_hit;

  // Abort only when a finite timeout is configured and the counter has
  // reached the final waiting cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state and payload logic. The APB control outputs and the handshake
  // outputs are derived from the next state so that every output comes
  // straight from a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is low in the first cycle after reset, so a command
        // can only be taken once the ready indication is actually visible.
        if (cmd_valid && cmd_ready_q) begin
          state_d  = ST_SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          cnt_d    = '0;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end

      ST_ACCESS: begin
        // pready wins over the timeout, so a slave answering on the very
        // last allowed cycle still completes normally.
        if (pready) begin
          state_d       = ST_RESP;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            state_d       = ST_RESP;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers. Reset clears everything at once, so a
  // transfer in flight drops psel/penable immediately and any pending
  // response is lost.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
//
// Purpose:
//   Self-checking bench for apb_master_ctrl. A transaction-level model
//   predicts, from each accepted command and the slave wait profile, the
//   window of cycles in which psel, penable and rsp_valid must be high and
//   the response contents; a compare process checks the DUT against it on
//   every falling edge. Directed transactions add literal expectations for
//   latency, ACCESS length and response data.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave profile for the next command: pready low for p_wait ACCESS cycles
  // (negative = never), then pready high with p_err/p_rdata.
  int                p_wait  = 0;
  logic              p_err   = 1'b0;
  logic [DATA_W-1:0] p_rdata = '0;

  // Model state: one outstanding transaction described by its accept cycle
  // and the number of ACCESS cycles it must take.
  int                m_cyc       = 0;
  int                m_idle_from = 0;
  bit                m_busy      = 1'b0;
  int                m_a         = 0;
  int                m_len       = 0;
  int                m_acc       = 0;
  int                m_wait      = 0;
  logic              m_slv_err   = 1'b0;
  logic [DATA_W-1:0] m_slv_rdata = '0;
  logic              m_write     = 1'b0;
  logic [ADDR_W-1:0] m_addr      = '0;
  logic [DATA_W-1:0] m_pwdata    = '0;
  logic [DATA_W-1:0] m_rdata_exp = '0;
  logic              m_err_exp   = 1'b0;
  logic              m_to_exp    = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process and model update, once per cycle on the falling edge.
  initial begin : compare_proc
    logic e_cr, e_psel, e_pen, e_rv;
    forever begin
      @(negedge pclk);
      if (preset) begin
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_psel",      psel,      0);
        checkOutput("rst_penable",   penable,   0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        m_busy      = 1'b0;
        m_idle_from = m_cyc + 2;
      end else begin
        e_cr   = !m_busy && (m_cyc >= m_idle_from);
        e_psel = m_busy && (m_cyc >= m_a + 1) && (m_cyc <= m_a + 1 + m_len);
        e_pen  = m_busy && (m_cyc >= m_a + 2) && (m_cyc <= m_a + 1 + m_len);
        e_rv   = m_busy && (m_cyc >= m_a + 2 + m_len);
        checkOutput("cmd_ready", cmd_ready, e_cr);
        checkOutput("psel",      psel,      e_psel);
        checkOutput("penable",   penable,   e_pen);
        checkOutput("rsp_valid", rsp_valid, e_rv);
        if (e_psel) begin
          checkOutput("paddr",  paddr,  m_addr);
          checkOutput("pwrite", pwrite, m_write);
          checkOutput("pwdata", pwdata, m_pwdata);
        end
        if (e_rv) begin
          checkOutput("rsp_rdata",   rsp_rdata,   m_rdata_exp);
          checkOutput("rsp_err",     rsp_err,     m_err_exp);
          checkOutput("rsp_timeout", rsp_timeout, m_to_exp);
        end
        if (e_rv && rsp_ready) begin
          m_busy      = 1'b0;
          m_idle_from = m_cyc + 1;
        end else if (e_cr && cmd_valid) begin
          m_busy      = 1'b1;
          m_a         = m_cyc;
          m_write     = cmd_write;
          m_addr      = cmd_addr;
          m_pwdata    = cmd_write ? cmd_wdata : '0;
          m_wait      = p_wait;
          m_slv_err   = p_err;
          m_slv_rdata = p_rdata;
          m_to_exp    = (p_wait < 0) || (p_wait >= TIMEOUT);
          m_len       = m_to_exp ? TIMEOUT : p_wait + 1;
          m_err_exp   = m_to_exp || p_err;
          m_rdata_exp = (m_to_exp || cmd_write) ? '0 : p_rdata;
          m_acc++;
        end
      end
      m_cyc++;
    end
  end

  // APB slave: follows the model's ACCESS window. Outside the point where
  // pready is high it drives junk to show the DUT ignores it.
  initial begin : slave_proc
    int k;
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      k = m_cyc - (m_a + 2);
      if (m_busy && k >= 0 && k < m_len) begin
        pready = (m_wait >= 0) && (k >= m_wait);
        if (pready) begin
          prdata  = m_slv_rdata;
          pslverr = m_slv_err;
        end else begin
          prdata  = 32'hBAD0_0000 | 32'(k);
          pslverr = 1'b1;
        end
      end else begin
        pready  = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  // One command through to its response handshake. Called and returns just
  // after a rising edge. lat = cycles from accept to first rsp_valid,
  // pen = cycles with penable high.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int wait_n, input logic err, input logic [31:0] rdata,
                               input int hold, input logic [31:0] exp_pwdata,
                               input logic [31:0] exp_rdata, input logic exp_err, input logic exp_to,
                               output int lat, output int pen);
    int acc0;
    bit accepted;
    bit got;
    p_wait    = wait_n;
    p_err     = err;
    p_rdata   = rdata;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    acc0      = m_acc;
    accepted  = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(posedge pclk);
      #1;
      if (m_acc != acc0) accepted = 1'b1;
    end
    checkOutput("accept_in_time", accepted, 1);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    got = 1'b0;
    lat = 0;
    pen = 0;
    for (int d = 1; d < 64; d++) begin
      @(negedge pclk);
      if (d == 1) begin
        checkOutput("setup_psel",    psel,    1);
        checkOutput("setup_penable", penable, 0);
        checkOutput("setup_paddr",   paddr,   addr);
        checkOutput("setup_pwdata",  pwdata,  exp_pwdata);
      end
      if (penable) pen++;
      if (rsp_valid) begin
        lat = d;
        got = 1'b1;
        break;
      end
      @(posedge pclk);
      #1;
    end
    checkOutput("rsp_in_time", got, 1);
    checkOutput("lit_rsp_rdata",   rsp_rdata,   exp_rdata);
    checkOutput("lit_rsp_err",     rsp_err,     exp_err);
    checkOutput("lit_rsp_timeout", rsp_timeout, exp_to);
    for (int i = 0; i < hold; i++) begin
      @(posedge pclk);
      #1;
      @(negedge pclk);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("hold_rsp_err",   rsp_err,   exp_err);
    end
    @(posedge pclk);
    #1;
    rsp_ready = 1'b1;
    @(posedge pclk);
    #1;
    rsp_ready = 1'b0;
    @(negedge pclk);
    checkOutput("ready_after_hs", cmd_ready, 1);
    @(posedge pclk);
    #1;
  endtask

  // Read that never gets pready, with reset asserted two cycles into ACCESS.
  task automatic resetDuringAccess();
    int acc0;
    bit accepted;
    p_wait    = -1;
    p_err     = 1'b0;
    p_rdata   = 32'h1111_2222;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0040;
    cmd_valid = 1'b1;
    acc0      = m_acc;
    accepted  = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(posedge pclk);
      #1;
      if (m_acc != acc0) accepted = 1'b1;
    end
    checkOutput("rst_accept_in_time", accepted, 1);
    cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge pclk);
      #1;
    end
    checkOutput("pre_rst_penable", penable, 1);
    preset = 1'b1;
    #1;
    checkOutput("async_psel",      psel,      0);
    checkOutput("async_penable",   penable,   0);
    checkOutput("async_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("rel_cmd_ready_0", cmd_ready, 0);
    @(posedge pclk);
    #1;
    @(negedge pclk);
    checkOutput("rel_cmd_ready_1", cmd_ready, 1);
    @(posedge pclk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main_proc
    int lat, pen;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;

    // Reset release and idle behaviour.
    repeat (3) @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("idle_cmd_ready_0", cmd_ready, 0);
    repeat (4) begin
      @(posedge pclk);
      #1;
      @(negedge pclk);
      checkOutput("idle_cmd_ready", cmd_ready, 1);
      checkOutput("idle_psel",      psel,      0);
    end
    @(posedge pclk);
    #1;

    // Zero-wait write.
    applyStimulus(1'b1, 32'h0000_0000, 32'h0000_06D5, 0, 1'b0, 32'hFFFF_FFFF, 0,
                  32'h0000_06D5, 32'h0, 1'b0, 1'b0, lat, pen);
    checkOutput("wr_latency", lat, 3);
    checkOutput("wr_penable_cycles", pen, 1);
    checkOutput("model_len_wr", m_len, 1);

    // Read with three wait cycles.
    applyStimulus(1'b0, 32'h0000_0012, 32'h5555_5555, 3, 1'b0, 32'hDEAD_BEEF, 1,
                  32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, lat, pen);
    checkOutput("rd_wait_latency", lat, 6);
    checkOutput("rd_wait_penable_cycles", pen, 4);
    checkOutput("model_len_rd_wait", m_len, 4);

    // Read that times out.
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, -1, 1'b0, 32'hCAFE_F00D, 0,
                  32'h0, 32'h0, 1'b1, 1'b1, lat, pen);
    checkOutput("to_latency", lat, 18);
    checkOutput("to_penable_cycles", pen, 16);

    // Write with slave error and a held-off response.
    applyStimulus(1'b1, 32'h0000_0008, 32'h0000_00A5, 0, 1'b1, 32'h0, 5,
                  32'h0000_00A5, 32'h0, 1'b1, 1'b0, lat, pen);
    checkOutput("slverr_latency", lat, 3);

    // pready on the last allowed ACCESS cycle completes without timeout.
    applyStimulus(1'b0, 32'h0000_0030, 32'h0, 15, 1'b0, 32'h0BAD_F00D, 0,
                  32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, lat, pen);
    checkOutput("edge_latency", lat, 18);
    checkOutput("edge_penable_cycles", pen, 16);

    // Reset mid-transfer, then a clean write.
    resetDuringAccess();
    applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 1, 1'b0, 32'h0, 0,
                  32'h1234_5678, 32'h0, 1'b0, 1'b0, lat, pen);
    checkOutput("post_rst_latency", lat, 4);
    checkOutput("post_rst_penable_cycles", pen, 2);

    repeat (3) @(posedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
